// File: rtl/lut_coeff_loader.sv
// Loads DEPTH coefficient words from a valid/ready stream into a single-port LUT,
// then reads the table back and compares additive checksums of written and read data.
module lut_coeff_loader #(
  parameter int DEPTH        = 3072,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic [31:0]           lut_data,
  output logic                  lut_wren,
  output logic                  lut_rden,
  input  logic [31:0]           lut_q,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WFLUSH = 3'd2,
    VERIFY = 3'd3,
    DRAIN  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r;
  logic [31:0]             wsum_r, rsum_r, rsum_s;
  logic [READ_LATENCY-1:0] tag_r, tag_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             data_r, checksum_r;
  logic                    wren_r, rden_r, busy_r, done_r, error_r;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign in_ready    = (state_r == LOAD) && (cnt_r < CNT_FULL);
  assign lut_address = addr_r;
  assign lut_data    = data_r;
  assign lut_wren    = wren_r;
  assign lut_rden    = rden_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign checksum    = checksum_r;

  // Next-state logic, read-tag pipeline advance and read-sum accumulation.
  always_comb begin
    state_s  = state_r;
    accept_s = in_valid & in_ready;
    tag_s    = {READ_LATENCY{1'b0}};
    tag_s[0] = rden_r;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_s[i] = tag_r[i-1];
    end
    if (tag_r[READ_LATENCY-1]) begin
      rsum_s = add32(rsum_r, lut_q);
    end else begin
      rsum_s = rsum_r;
    end
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (accept_s && (cnt_r == CNT_LAST)) state_s = WFLUSH;
        else                                 state_s = LOAD;
      end
      WFLUSH: state_s = VERIFY;
      VERIFY: begin
        if (cnt_r == CNT_LAST) state_s = DRAIN;
        else                   state_s = VERIFY;
      end
      // Finish only once no read is still in flight after this edge.
      DRAIN: begin
        if (tag_s == {READ_LATENCY{1'b0}}) state_s = FIN;
        else                               state_s = DRAIN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Datapath registers: LUT pins, counters, sums and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= CNT_ZERO;
      wsum_r     <= 32'd0;
      rsum_r     <= 32'd0;
      tag_r      <= {READ_LATENCY{1'b0}};
      addr_r     <= {ADDR_WIDTH{1'b0}};
      data_r     <= 32'd0;
      wren_r     <= 1'b0;
      rden_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      checksum_r <= 32'd0;
    end else begin
      wren_r <= 1'b0;
      rden_r <= 1'b0;
      done_r <= 1'b0;
      tag_r  <= tag_s;
      rsum_r <= rsum_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r      <= CNT_ZERO;
            wsum_r     <= 32'd0;
            rsum_r     <= 32'd0;
            tag_r      <= {READ_LATENCY{1'b0}};
            error_r    <= 1'b0;
            checksum_r <= 32'd0;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            wren_r <= 1'b1;
            data_r <= in_data;
            addr_r <= ADDR_WIDTH'(cnt_r);
            cnt_r  <= cnt_r + CNT_ONE;
            wsum_r <= add32(wsum_r, in_data);
          end
        end
        WFLUSH: cnt_r <= CNT_ZERO;
        VERIFY: begin
          rden_r <= 1'b1;
          addr_r <= ADDR_WIDTH'(cnt_r);
          if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CNT_ONE;
        end
        // rsum_s already includes the final read returning on this edge.
        DRAIN: begin
          if (state_s == FIN) begin
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            error_r    <= (wsum_r != rsum_s);
            checksum_r <= wsum_r;
          end
        end
        FIN: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_coeff_loader.sv
// Directed self-checking bench for lut_coeff_loader (DEPTH=4, READ_LATENCY=2) with a
// behavioural single-port LUT that has registered address and registered output.
module tb_lut_coeff_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int RL    = 2;
  localparam int NCYC  = 30;

  logic          clock = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic [31:0]   in_data, lut_data, lut_q, checksum;
  logic [AW-1:0] lut_address;
  logic          lut_wren, lut_rden, busy, done, error;

  always #5 clock = ~clock;

  lut_coeff_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .lut_address(lut_address), .lut_data(lut_data), .lut_wren(lut_wren),
    .lut_rden(lut_rden), .lut_q(lut_q),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  // LUT model: address register then output register; optional corruption of address 2.
  logic [31:0]   mem [0:7];
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic [31:0]   q_r;
  bit            corrupt = 1'b0;
  always @(posedge clock) begin
    if (lut_wren) mem[lut_address] <= lut_data;
    addr_q <= lut_address;
    rd_q   <= lut_rden;
    if (rd_q) q_r <= (corrupt && addr_q == 3'd2) ? 32'd0 : mem[addr_q];
  end
  assign lut_q = q_r;

  int n_cmp = 0;
  int n_bad = 0;

  int            wr_n, rd_n, done_n, done_cyc, acc_n, overlap_n;
  int            wr_cyc [8];
  logic [AW-1:0] wr_addr [8];
  logic [31:0]   wr_dat [8];
  int            rd_cyc [8];
  logic [AW-1:0] rd_addr [8];
  logic          wren_at [NCYC+1];
  logic          busy_at [NCYC+1];
  logic          rdy_at [NCYC+1];
  logic          err_at [NCYC+1];

  // Start pulse sampled at edge 0; cycle n is observed at the negedge just before edge n.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input bit alt, input bit hold,
                          input int restart_cyc, input int reset_cyc);
    logic [31:0] w [4];
    int k;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    k = 0; wr_n = 0; rd_n = 0; done_n = 0; done_cyc = -1; acc_n = 0; overlap_n = 0;
    @(negedge clock);
    start = 1'b1; in_valid = 1'b0; reset = 1'b0;
    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(negedge clock);
      wren_at[cyc] = lut_wren; busy_at[cyc] = busy; rdy_at[cyc] = in_ready; err_at[cyc] = error;
      if (lut_wren) begin
        if (wr_n < 8) begin
          wr_cyc[wr_n] = cyc; wr_addr[wr_n] = lut_address; wr_dat[wr_n] = lut_data;
        end
        wr_n++;
      end
      if (lut_rden) begin
        if (rd_n < 8) begin
          rd_cyc[rd_n] = cyc; rd_addr[rd_n] = lut_address;
        end
        rd_n++;
      end
      if (lut_wren && lut_rden) overlap_n++;
      if (done) begin
        done_n++; done_cyc = cyc;
      end
      start = (cyc == restart_cyc);
      reset = (cyc == reset_cyc);
      if (k < 4) begin
        in_valid = alt ? (cyc % 2 == 1) : 1'b1;
        in_data  = w[k];
      end else begin
        in_valid = hold;
        in_data  = 32'hDEAD_BEEF;
      end
      if (in_valid && in_ready) begin
        acc_n++; k++;
      end
    end
    start = 1'b0; in_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    repeat (3) @(negedge clock);
    n_cmp++; if ({in_ready, lut_wren, lut_rden, busy, done, error} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 000000", {in_ready, lut_wren, lut_rden, busy, done, error}); end
    n_cmp++; if (lut_address !== 3'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", lut_address); end
    n_cmp++; if (lut_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", lut_data); end
    n_cmp++; if (checksum !== 32'd0) begin n_bad++; $display("FAIL reset_checksum: got %h want 0", checksum); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_stream();
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (wr_n !== 4) begin n_bad++; $display("FAIL t1_wr_count: got %0d want 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wr_cyc[i] !== 2 + i) begin n_bad++; $display("FAIL t1_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 2 + i); end
      n_cmp++; if (wr_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL t1_wr_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
      n_cmp++; if (wr_dat[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL t1_wr_data[%0d]: got %0d want %0d", i, wr_dat[i], i + 1); end
      n_cmp++; if (rd_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL t1_rd_addr[%0d]: got %0d want %0d", i, rd_addr[i], i); end
      n_cmp++; if (rd_cyc[i] !== 7 + i) begin n_bad++; $display("FAIL t1_rd_cycle[%0d]: got %0d want %0d", i, rd_cyc[i], 7 + i); end
    end
    n_cmp++; if (rd_n !== 4) begin n_bad++; $display("FAIL t1_rd_count: got %0d want 4", rd_n); end
    n_cmp++; if (overlap_n !== 0) begin n_bad++; $display("FAIL t1_rw_overlap: got %0d want 0", overlap_n); end
    n_cmp++; if (done_n !== 1 || done_cyc !== 13) begin n_bad++; $display("FAIL t1_done: got %0d pulses at %0d want 1 at 13", done_n, done_cyc); end
    n_cmp++; if (busy_at[1] !== 1'b1 || busy_at[12] !== 1'b1 || busy_at[13] !== 1'b0) begin n_bad++; $display("FAIL t1_busy: got %b%b%b want 110", busy_at[1], busy_at[12], busy_at[13]); end
    n_cmp++; if (checksum !== 32'd10) begin n_bad++; $display("FAIL t1_checksum: got %0d want 10", checksum); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL t1_error: got %b want 0", error); end
    n_cmp++; if (lut_address !== 3'd3) begin n_bad++; $display("FAIL t1_addr_hold: got %0d want 3", lut_address); end
  endtask

  task automatic test_bubbles();
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (wr_n !== 4) begin n_bad++; $display("FAIL t2_wr_count: got %0d want 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL t2_wr_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
      n_cmp++; if (wr_cyc[i] !== 2 + 2 * i) begin n_bad++; $display("FAIL t2_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 2 + 2 * i); end
    end
    n_cmp++; if (done_n !== 1 || done_cyc !== 16) begin n_bad++; $display("FAIL t2_done: got %0d pulses at %0d want 1 at 16", done_n, done_cyc); end
    n_cmp++; if (checksum !== 32'd10) begin n_bad++; $display("FAIL t2_checksum: got %0d want 10", checksum); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL t2_error: got %b want 0", error); end
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL t3_error: got %b want 1", error); end
    n_cmp++; if (checksum !== 32'd10) begin n_bad++; $display("FAIL t3_checksum: got %0d want 10", checksum); end
    repeat (5) @(negedge clock);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL t3_error_held: got %b want 1", error); end
    corrupt = 1'b0;
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (err_at[1] !== 1'b0) begin n_bad++; $display("FAIL t3_error_clear_on_start: got %b want 0", err_at[1]); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL t3_error_rerun: got %b want 0", error); end
  endtask

  task automatic test_wrap();
    run_load(32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (checksum !== 32'h0000_0001) begin n_bad++; $display("FAIL t4_checksum: got %h want 00000001", checksum); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL t4_error: got %b want 0", error); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL t4_done: got %0d want 1", done_n); end
  endtask

  task automatic test_midload_reset();
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, -1, 4);
    n_cmp++; if (wr_n !== 3) begin n_bad++; $display("FAIL t5_wr_count: got %0d want 3", wr_n); end
    n_cmp++; if ({wren_at[5], busy_at[5], rdy_at[5]} !== 3'b000) begin n_bad++; $display("FAIL t5_after_reset: got %b want 000", {wren_at[5], busy_at[5], rdy_at[5]}); end
    n_cmp++; if (done_n !== 0) begin n_bad++; $display("FAIL t5_no_done: got %0d want 0", done_n); end
    run_load(32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (wr_n !== 4 || wr_addr[0] !== 3'd0 || wr_addr[3] !== 3'd3) begin n_bad++; $display("FAIL t5_reload: got %0d writes first %0d last %0d want 4/0/3", wr_n, wr_addr[0], wr_addr[3]); end
    n_cmp++; if (checksum !== 32'd26 || error !== 1'b0) begin n_bad++; $display("FAIL t5_reload_sum: got %0d err %b want 26 err 0", checksum, error); end
    n_cmp++; if (done_cyc !== 13) begin n_bad++; $display("FAIL t5_reload_done: got %0d want 13", done_cyc); end
  endtask

  task automatic test_busy_start_and_overrun();
    run_load(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 3, -1);
    n_cmp++; if (acc_n !== 4) begin n_bad++; $display("FAIL t6_accepts: got %0d want 4", acc_n); end
    n_cmp++; if (wr_n !== 4) begin n_bad++; $display("FAIL t6_wr_count: got %0d want 4", wr_n); end
    n_cmp++; if (wr_dat[3] !== 32'd4) begin n_bad++; $display("FAIL t6_last_data: got %h want 4", wr_dat[3]); end
    n_cmp++; if (rdy_at[5] !== 1'b0) begin n_bad++; $display("FAIL t6_ready_dropped: got %b want 0", rdy_at[5]); end
    n_cmp++; if (done_n !== 1 || done_cyc !== 13) begin n_bad++; $display("FAIL t6_done: got %0d pulses at %0d want 1 at 13", done_n, done_cyc); end
    n_cmp++; if (checksum !== 32'd10) begin n_bad++; $display("FAIL t6_checksum: got %0d want 10", checksum); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bubbles();
    test_corrupt();
    test_wrap();
    test_midload_reset();
    test_busy_start_and_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_coeff_loader.md
Name: lut_coeff_loader

Overview:
- Runtime writer for the single-port 32-bit coefficient LUTs (altera_syncram, SINGLE_PORT, output registered).
- Accepts a valid/ready stream of DEPTH coefficient words and writes them to LUT addresses 0..DEPTH-1.
- Then reads the whole table back and compares a 32-bit additive checksum of the written and read data.
- Sits between the host-side coefficient stream and each LUT instance's address/data/wren/rden/q pins.

Parameters:
DEPTH, 3072, number of LUT words to load; DEPTH >= 2
ADDR_WIDTH, 12, LUT address width; 2^ADDR_WIDTH >= DEPTH
READ_LATENCY, 2, cycles from rden asserted to valid lut_q (address register plus output register)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a load when idle
in_data  in  32  coefficient word
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts in_data this cycle
lut_address  out  ADDR_WIDTH  LUT address
lut_data  out  32  LUT write data
lut_wren  out  1  LUT write enable
lut_rden  out  1  LUT read enable
lut_q  in  32  LUT read data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
error  out  1  checksum mismatch of last run; held until next accepted start
checksum  out  32  sum of written words mod 2^32; held until next accepted start

Behaviour:
- Reset state: all outputs 0. State is IDLE. Counters and sums are 0. Reset has priority in every state, including mid-load. A write in flight is dropped and lut_wren is 0 after the reset edge.
- States: IDLE, LOAD, WFLUSH, VERIFY, DRAIN, FIN.
- IDLE:
  - start=1 moves to LOAD.
  - Clears the word counter, wsum, rsum, error and checksum.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1 combinationally while in LOAD and accepted count < DEPTH.
  - Accept = in_valid & in_ready.
  - On accept, the next cycle drives lut_wren=1, lut_data=in_data, lut_address=count. count increments and wsum += in_data, mod 2^32.
  - Without an accept, lut_wren=0 the next cycle. Bubbles are allowed; the address advances only on accept.
  - After the DEPTH-th accept, go to WFLUSH and drop in_ready.
- WFLUSH: one cycle. The last write completes. No read is issued in the same cycle as a write, so read-during-write is never exercised.
- VERIFY:
  - Drives lut_rden=1 with lut_address = 0..DEPTH-1, one address per cycle; lut_wren=0.
  - A READ_LATENCY-deep valid shift register tags each read.
  - When a tag emerges, rsum += lut_q.
  - After issuing address DEPTH-1, go to DRAIN with lut_rden=0.
- DRAIN:
  - Waits until all READ_LATENCY outstanding tags are consumed.
  - Then goes to FIN.
- FIN:
  - done=1 for one cycle.
  - error = (wsum != rsum).
  - checksum = wsum.
  - busy=0.
  - Returns to IDLE.
- Latency with in_valid held high: start at cycle 0. The first accept is at cycle 1. The last write is at cycle DEPTH+1. Reads run from cycle DEPTH+3 to cycle 2*DEPTH+2. done is at cycle 2*DEPTH+3+READ_LATENCY.
- Address wrap: never. Counters stop at DEPTH-1. lut_address holds its last value while idle.
- Extra in_valid after DEPTH words: not accepted; in_ready stays low.
- Arithmetic is unsigned 32-bit wraparound. Overflow is not flagged.

Test Plan (DEPTH=4, READ_LATENCY=2 unless noted):
1. Reset, then start, then stream words 1,2,3,4 with in_valid held high:
   - lut_wren high for 4 consecutive cycles at addresses 0..3, data 1..4.
   - Reads at addresses 0..3.
   - done pulse at cycle 13; checksum=10; error=0.
2. Same stream with in_valid low on alternate cycles:
   - Writes at addresses 0..3 with gaps; no address skipped.
   - Final checksum=10, error=0, done later by exactly the number of bubbles.
3. Bench memory model corrupts address 2 on readback (returns 0):
   - error=1, checksum=10.
   - error stays 1 until the next start, then clears.
4. Words 0xFFFFFFFF, 0x00000002, 0, 0:
   - checksum=0x00000001 (wraparound), error=0.
5. Assert reset during the third write cycle:
   - Next cycle lut_wren=0, busy=0, in_ready=0, done never pulses.
   - A subsequent start reloads from address 0 cleanly.
6. Pulse start while busy, and hold in_valid after 4 words:
   - No restart, no fifth accept.
   - Exactly 4 writes, single done.
